slow_signal_sched: RTL

- Time-multiplexed debounce/hysteresis scheduler for the slow front-panel/status lines of the HP859x display interface.
- Holds one saturating counter per channel in a register array and sequences a single shared update datapath across all channels, one channel per clock, once per sample tick.
- Produces filtered levels, a per-scan change mask and a status flag for dropped ticks.
- Replaces N separate per-line filter instances: one adder/comparator pair is shared by every line.

---
 rtl/slow_signal_sched_pkg.sv | 24 ++
 rtl/slow_signal_sched_if.sv | 45 ++++
 rtl/slow_signal_sched_upd.sv | 33 +++
 rtl/slow_signal_sched.sv | 130 +++++++++++++
 4 files changed

// File: rtl/slow_signal_sched_pkg.sv
// Shared types and thresholds for the slow-line scheduler.
// Build option: SLOW_SIGNAL_SCHED_CHG_EN adds the change mask.
package slow_signal_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    function automatic int hi_thr(input int w);
        return (1 << (w - 1)) + 1;
    endfunction

    function automatic int lo_thr(input int w);
        return (1 << (w - 1)) - 4;
    endfunction

    // Channel index width, never zero.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/slow_signal_sched_if.sv
// Tick/level bundle between the panel logic and the scheduler.
// Build option: SLOW_SIGNAL_SCHED_CHG_EN adds chg/chg_vld.
interface slow_signal_sched_if #(
    parameter int CHANNELS = 8
);
    import slow_signal_pkg::*;

    localparam int IW = idx_w(CHANNELS);

    logic                tick;
    logic [CHANNELS-1:0] src;
    logic                ovr_clr;
    logic [CHANNELS-1:0] slow;
    logic                busy;
    logic [IW-1:0]       cur_ch;
    logic                overrun;

`ifdef SLOW_SIGNAL_SCHED_CHG_EN
    logic [CHANNELS-1:0] chg;
    logic                chg_vld;

    modport master (
        output tick, src, ovr_clr,
        input  slow, busy, cur_ch, overrun,
        input  chg, chg_vld
    );

    modport slave (
        input  tick, src, ovr_clr,
        output slow, busy, cur_ch, overrun,
        output chg, chg_vld
    );
`else
    modport master (
        output tick, src, ovr_clr,
        input  slow, busy, cur_ch, overrun
    );

    modport slave (
        input  tick, src, ovr_clr,
        output slow, busy, cur_ch, overrun
    );
`endif

endinterface

// File: rtl/slow_signal_sched_upd.sv
// One-channel saturating counter step with hysteresis on the level.
// Purely combinational; the scheduler shares one copy over all lines.
module slow_signal_upd
    import slow_signal_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] c,
    input  logic         s,
    input  logic         old,
    output logic [W-1:0] nc,
    output logic         ns
);

    localparam logic [W-1:0] HI  = W'(hi_thr(W));
    localparam logic [W-1:0] LO  = W'(lo_thr(W));
    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] ONE = W'(1);

    // Thresholds compare the count before this step.
    always_comb begin
        nc = c;
        ns = old;
        if (s) begin
            if (c != MAX) nc = c + ONE;
            if (c >= HI)  ns = 1'b1;
        end else begin
            if (c != '0)  nc = c - ONE;
            if (c <= LO)  ns = 1'b0;
        end
    end

endmodule

// File: rtl/slow_signal_sched.sv
// Time-multiplexed debounce scheduler: one channel per clock per tick.
// Build option: SLOW_SIGNAL_SCHED_CHG_EN adds the per-scan change mask.
module slow_signal_sched
    import slow_signal_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int RATIO    = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    slow_signal_sched_if.slave bus
);

    localparam int W  = $clog2(RATIO);
    localparam int IW = idx_w(CHANNELS);

    localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);
    localparam logic [IW-1:0] STEP = IW'(1);

    state_t              state;
    logic [IW-1:0]       idx;
    logic [CHANNELS-1:0] src_q;
    logic [CHANNELS-1:0] slow_q;
    logic [W-1:0]        cnt [CHANNELS];
    logic                busy_q;
    logic [IW-1:0]       cur_q;
    logic                ovr_q;

    logic [W-1:0]        c_nxt;
    logic                s_nxt;

    slow_signal_upd #(
        .W (W)
    ) u_upd (
        .c   (cnt[idx]),
        .s   (src_q[idx]),
        .old (slow_q[idx]),
        .nc  (c_nxt),
        .ns  (s_nxt)
    );

`ifdef SLOW_SIGNAL_SCHED_CHG_EN
    logic [CHANNELS-1:0] acc;
    logic [CHANNELS-1:0] chg_q;
    logic                chg_vld_q;
    logic [CHANNELS-1:0] tog;

    always_comb begin
        tog      = '0;
        tog[idx] = s_nxt ^ slow_q[idx];
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            src_q  <= '0;
            slow_q <= '0;
            busy_q <= 1'b0;
            cur_q  <= '0;
            ovr_q  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++)
                cnt[i] <= '0;
`ifdef SLOW_SIGNAL_SCHED_CHG_EN
            acc       <= '0;
            chg_q     <= '0;
            chg_vld_q <= 1'b0;
`endif
        end else begin
            // A dropped tick outranks a same-cycle clear.
            if (bus.tick && state != IDLE)
                ovr_q <= 1'b1;
            else if (bus.ovr_clr)
                ovr_q <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (bus.tick) begin
                        src_q  <= bus.src;
                        idx    <= '0;
                        cur_q  <= '0;
                        busy_q <= 1'b1;
                        state  <= SCAN;
`ifdef SLOW_SIGNAL_SCHED_CHG_EN
                        acc    <= '0;
`endif
                    end
                end
                SCAN: begin
                    cnt[idx]    <= c_nxt;
                    slow_q[idx] <= s_nxt;
`ifdef SLOW_SIGNAL_SCHED_CHG_EN
                    acc <= acc | tog;
`endif
                    if (idx == LAST) begin
                        state <= DONE;
                        cur_q <= '0;
`ifdef SLOW_SIGNAL_SCHED_CHG_EN
                        chg_q     <= acc | tog;
                        chg_vld_q <= 1'b1;
`endif
                    end else begin
                        idx   <= idx + STEP;
                        cur_q <= idx + STEP;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
`ifdef SLOW_SIGNAL_SCHED_CHG_EN
                    chg_q     <= '0;
                    chg_vld_q <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.slow    = slow_q;
    assign bus.busy    = busy_q;
    assign bus.cur_ch  = cur_q;
    assign bus.overrun = ovr_q;
`ifdef SLOW_SIGNAL_SCHED_CHG_EN
    assign bus.chg     = chg_q;
    assign bus.chg_vld = chg_vld_q;
`endif

endmodule
